store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of buffered stores; legal values are 2, 4 and 8.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port st_valid, input, 1 bit: the pipeline presents a store.
REQ-005 The block SHALL have ports st_addr and st_data, input, 24 bits each: the store address and store data.
REQ-006 The block SHALL have port st_ready, output, 1 bit: the buffer can accept a store this cycle.
REQ-007 The block SHALL have ports ld_valid, input, 1 bit, and ld_addr, input, 24 bits: the pipeline performs a load this cycle.
REQ-008 The block SHALL have ports ld_hit, output, 1 bit, and ld_data, output, 24 bits: forwarded load data.
REQ-009 The block SHALL have port ld_conflict, output, 1 bit: the load must stall.
REQ-010 The block SHALL have ports memWrite and memRead, output, 1 bit each, driving the data memory port.
REQ-011 The block SHALL have ports address and write_data, output, 24 bits each, driving the data memory port.
REQ-012 The block SHALL have ports empty, output, 1 bit, and count, output, 4 bits: occupancy.

Function
REQ-013 The block SHALL hold a circular FIFO of DEPTH entries, each holding {addr, data}, with head and tail pointers wrapping modulo DEPTH.
REQ-014 The block SHALL assert st_ready exactly when count < DEPTH; a push SHALL NOT be allowed when full, even if a pop occurs in the same cycle.
REQ-015 The block SHALL write a store into the tail entry on the rising edge where st_valid && st_ready is true, and then advance tail.
REQ-016 Memory port arbitration SHALL be combinational and give the load priority:
- When ld_valid=1: address=ld_addr, memRead=1, memWrite=0.
- Otherwise, when count>0: address=head addr, write_data=head data, memWrite=1, memRead=0.
- Otherwise: memWrite=0, memRead=0, and address and write_data are zero.
REQ-017 The head entry SHALL pop on the rising edge of any cycle with memWrite=1; a store therefore reaches memory no earlier than the cycle after it is pushed.
REQ-018 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-019 Address matching for loads SHALL compare bits [11:0] only, which is the memory's index width.
REQ-020 With forwarding enabled, the forwarding outputs SHALL behave as follows:
- ld_hit=1 when ld_valid is asserted and any valid entry matches.
- ld_data SHALL be the data of the youngest matching entry.
- An entry SHALL remain forwardable in its pop cycle.
- A store being pushed in the same cycle SHALL NOT be forwarded.
REQ-021 When ld_hit=0 the pipeline SHALL take load data from memory, and ld_data SHALL be zero.
REQ-022 The block SHALL assert empty exactly when count == 0.

Reset
REQ-023 Asserting reset SHALL asynchronously clear head, tail and count and invalidate all entries.
REQ-024 While reset is asserted, all outputs SHALL read zero except st_ready=1 and empty=1.
REQ-025 Stores that are buffered when reset asserts SHALL be discarded and never written to memory.
REQ-026 The first push SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-027 With macro STORE_FORWARD_EN defined, the block SHALL implement REQ-020 and hold ld_conflict at 0.
REQ-028 Without STORE_FORWARD_EN, the block SHALL behave as follows:
- ld_hit and ld_data SHALL be tied to 0.
- ld_conflict SHALL equal ld_valid && (count>0).
- Draining SHALL proceed in conflict cycles, because the load does not take the port while ld_conflict=1 and arbitration treats ld_valid as 0.

Verification
REQ-029 Reset, then push (0x000010, 0xABCDEF) with no loads -> memWrite=1, address=0x000010, write_data=0xABCDEF in the next cycle; empty=1 the cycle after.
REQ-030 Push 5 stores back-to-back with DEPTH=4 while ld_valid=1 holds off draining -> st_ready=0 after the 4th push and count=4; the 5th store is accepted only after ld_valid drops and one entry drains.
REQ-031 With forwarding enabled, push (0x000020, 0x111111) then (0x001020, 0x222222), then load 0x000020 -> ld_hit=1 and ld_data=0x222222, because the upper address bits are ignored and the youngest entry wins.
REQ-032 With forwarding disabled, load 0x000020 while count=2 -> ld_conflict=1 and memWrite=1 for 2 cycles; ld_conflict=0 and memRead=1 in the third cycle.
REQ-033 Push 3 stores, then assert reset in the middle of a cycle -> count=0 and empty=1 immediately; memWrite stays 0 after reset is released.
REQ-034 Push and drain simultaneously with count=2 for 10 cycles -> count stays 2, and memory writes occur in push order across the pointer wrap-around.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer: a DEPTH-entry circular FIFO of pending stores draining to a shared memory port.
// Define STORE_FORWARD_EN for store-to-load forwarding; otherwise loads stall behind buffered stores.

module store_buffer_entry (
  input  logic        i_vld,
  input  logic [11:0] i_idx,
  input  logic [11:0] i_ld_idx,
  output logic        o_match
);
  assign o_match = i_vld && (i_idx == i_ld_idx);
endmodule

module store_buffer #(
  parameter int DEPTH = 4  // 2, 4 or 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [23:0] st_addr,
  input  logic [23:0] st_data,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [23:0] ld_addr,
  output logic        ld_hit,
  output logic [23:0] ld_data,
  output logic        ld_conflict,
  output logic        memWrite,
  output logic        memRead,
  output logic [23:0] address,
  output logic [23:0] write_data,
  output logic        empty,
  output logic [3:0]  count
);
  localparam int              AW      = $clog2(DEPTH);
  localparam logic [3:0]      DEPTH_C = 4'(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE = 1;

  typedef struct packed {
    logic [23:0] addr;
    logic [23:0] data;
  } sb_entry_t;

  sb_entry_t [DEPTH-1:0] r_ent;
  logic [AW-1:0]         r_head;
  logic [AW-1:0]         r_tail;
  logic [3:0]            r_count;

  logic w_push;
  logic w_pop;
  logic w_ld;
  logic w_ld_port;
  logic w_conflict;

  // Loads are masked during reset so every load-side output reads zero.
  assign w_ld     = ld_valid && !reset;
  assign st_ready = (r_count < DEPTH_C);
  assign empty    = (r_count == 4'd0);
  assign count    = r_count;
  assign w_push   = st_valid && st_ready;
  assign w_pop    = memWrite;

`ifdef STORE_FORWARD_EN
  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] w_match;
  logic [AW-1:0]    w_idx;
  logic             w_hit;
  logic [23:0]      w_fwd;

  assign w_conflict = 1'b0;
  assign w_ld_port  = w_ld;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    store_buffer_entry u_ent (
      .i_vld    (r_vld[g]),
      .i_idx    (r_ent[g].addr[11:0]),
      .i_ld_idx (ld_addr[11:0]),
      .o_match  (w_match[g])
    );
  end

  // Walk oldest to youngest from head; the last match seen is the youngest.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    w_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + AW'(k);
      if (w_match[w_idx]) begin
        w_hit = 1'b1;
        w_fwd = r_ent[w_idx].data;
      end
    end
  end

  assign ld_hit      = w_ld && w_hit;
  assign ld_data     = ld_hit ? w_fwd : 24'd0;
  assign ld_conflict = 1'b0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      if (w_pop)  r_vld[r_head] <= 1'b0;
      if (w_push) r_vld[r_tail] <= 1'b1;
    end
  end
`else
  // Without forwarding the load yields the port until the buffer is empty.
  assign w_conflict  = w_ld && (r_count != 4'd0);
  assign w_ld_port   = w_ld && !w_conflict;
  assign ld_hit      = 1'b0;
  assign ld_data     = 24'd0;
  assign ld_conflict = w_conflict;
`endif

  always_comb begin
    memRead    = 1'b0;
    memWrite   = 1'b0;
    address    = 24'd0;
    write_data = 24'd0;
    if (w_ld_port) begin
      memRead = 1'b1;
      address = ld_addr;
    end else if (r_count != 4'd0) begin
      memWrite   = 1'b1;
      address    = r_ent[r_head].addr;
      write_data = r_ent[r_head].data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ent   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_ent[r_tail] <= '{addr: st_addr, data: st_data};
        r_tail        <= r_tail + PTR_ONE;
      end
      if (w_pop) r_head <= r_head + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: accepted stores queue up and every memory write is checked in order.
// Forwarding-specific scenarios are compiled in when STORE_FORWARD_EN is defined.

module tb_store_buffer;
  logic        clock = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [23:0] st_addr;
  logic [23:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [23:0] ld_addr;
  logic        ld_hit;
  logic [23:0] ld_data;
  logic        ld_conflict;
  logic        memWrite;
  logic        memRead;
  logic [23:0] address;
  logic [23:0] write_data;
  logic        empty;
  logic [3:0]  count;

  int checks   = 0;
  int failures = 0;
  logic [47:0] sb_q[$];

  store_buffer #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict),
    .memWrite(memWrite), .memRead(memRead), .address(address), .write_data(write_data),
    .empty(empty), .count(count)
  );

  always #5 clock = ~clock;

  // Monitor: pop the expected store for every memory write, then record this cycle's accepted store.
  always @(negedge clock) begin
    if (!reset) begin
      if (memWrite) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL mem_write_unexpected got addr=%06h data=%06h, required no write", address, write_data);
        end else begin
          logic [47:0] exp_w;
          exp_w = sb_q.pop_front();
          if ({address, write_data} !== exp_w) begin
            failures++;
            $display("FAIL mem_write_order got=%012h required=%012h", {address, write_data}, exp_w);
          end
        end
      end
      if (st_valid && st_ready) sb_q.push_back({st_addr, st_data});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [23:0] a, input logic [23:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    st_valid = 1'b0;
    ld_valid = 1'b0;
    while (!empty && n < 20) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, empty}, 32'd1);
    chk({nm, "_sb_left"}, sb_q.size(), 32'd0);
  endtask

  localparam logic [23:0] STREAM_A[6] = '{24'h000F00, 24'h000F04, 24'h123F08, 24'h000F0C, 24'h000F10, 24'h000F14};
  localparam logic [23:0] STREAM_D[6] = '{24'h010101, 24'h020202, 24'h030303, 24'h040404, 24'h050505, 24'h060606};

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    ld_valid = 1'b1;
    ld_addr  = 24'h123456;
    #2;
    chk("rst_st_ready", {31'd0, st_ready}, 32'd1);
    chk("rst_empty",    {31'd0, empty},    32'd1);
    chk("rst_count",    {28'd0, count},    32'd0);
    chk("rst_memRead",  {31'd0, memRead},  32'd0);
    chk("rst_memWrite", {31'd0, memWrite}, 32'd0);
    chk("rst_address",  {8'd0, address},   32'd0);
    chk("rst_conflict", {31'd0, ld_conflict}, 32'd0);
    chk("rst_ld_hit",   {31'd0, ld_hit},   32'd0);

    // First store accepted on the first edge after reset release, written the following cycle.
    tick();
    reset    = 1'b0;
    ld_valid = 1'b0;
    put(24'h000010, 24'hABCDEF);
    tick();
    st_valid = 1'b0;
    chk("first_count",      {28'd0, count},      32'd1);
    chk("first_memWrite",   {31'd0, memWrite},   32'd1);
    chk("first_address",    {8'd0, address},     32'h000010);
    chk("first_write_data", {8'd0, write_data},  32'hABCDEF);
    tick();
    chk("first_empty_after", {31'd0, empty}, 32'd1);
    chk("idle_memWrite", {31'd0, memWrite}, 32'd0);
    chk("idle_address",  {8'd0, address},   32'd0);

    // Load with an empty buffer owns the port.
    ld_valid = 1'b1;
    ld_addr  = 24'hABC123;
    #1;
    chk("load_memRead",  {31'd0, memRead},     32'd1);
    chk("load_address",  {8'd0, address},      32'hABC123);
    chk("load_conflict", {31'd0, ld_conflict}, 32'd0);
    chk("load_hit",      {31'd0, ld_hit},      32'd0);
    chk("load_data",     {8'd0, ld_data},      32'd0);
    ld_valid = 1'b0;
    tick();

    // Back-to-back stores across pointer wrap; each cycle pushes one and drains one.
    for (int i = 0; i < 6; i++) begin
      put(STREAM_A[i], STREAM_D[i]);
      tick();
      chk($sformatf("stream_count_%0d", i), {28'd0, count}, 32'd1);
    end
    drain("stream_drain");

`ifndef STORE_FORWARD_EN
    // Load behind buffered stores stalls while the stores drain, then takes the port.
    put(24'h000100, 24'h0000A1);
    tick();
    put(24'h000200, 24'h0000B2);
    ld_valid = 1'b1;
    ld_addr  = 24'h000300;
    #1;
    chk("conf1_conflict", {31'd0, ld_conflict}, 32'd1);
    chk("conf1_memWrite", {31'd0, memWrite},    32'd1);
    chk("conf1_memRead",  {31'd0, memRead},     32'd0);
    chk("conf1_address",  {8'd0, address},      32'h000100);
    tick();
    st_valid = 1'b0;
    #1;
    chk("conf2_conflict", {31'd0, ld_conflict}, 32'd1);
    chk("conf2_address",  {8'd0, address},      32'h000200);
    tick();
    chk("conf3_conflict", {31'd0, ld_conflict}, 32'd0);
    chk("conf3_memRead",  {31'd0, memRead},     32'd1);
    chk("conf3_address",  {8'd0, address},      32'h000300);
    chk("conf3_ld_hit",   {31'd0, ld_hit},      32'd0);
    chk("conf3_ld_data",  {8'd0, ld_data},      32'd0);
    ld_valid = 1'b0;
    tick();
`else
    // A held load blocks draining, so the buffer fills and refuses the fifth store.
    ld_valid = 1'b1;
    ld_addr  = 24'h000FFF;
    for (int i = 0; i < 4; i++) begin
      put(24'h000400 + 24'(i * 16), 24'h500000 + 24'(i));
      tick();
    end
    chk("full_count",    {28'd0, count},    32'd4);
    chk("full_st_ready", {31'd0, st_ready}, 32'd0);
    chk("full_memRead",  {31'd0, memRead},  32'd1);
    chk("full_memWrite", {31'd0, memWrite}, 32'd0);
    put(24'h000440, 24'h500004);
    tick();
    chk("full_hold_count", {28'd0, count}, 32'd4);
    ld_valid = 1'b0;
    #1;
    chk("full_pop_memWrite", {31'd0, memWrite}, 32'd1);
    chk("full_pop_st_ready", {31'd0, st_ready}, 32'd0);
    tick();
    chk("full_after_pop_count", {28'd0, count},    32'd3);
    chk("full_after_pop_ready", {31'd0, st_ready}, 32'd1);
    tick();
    chk("full_push_pop_count", {28'd0, count}, 32'd3);
    drain("full_drain");

    // Forwarding: upper address bits ignored, youngest entry wins, same-cycle push not forwarded.
    ld_valid = 1'b1;
    ld_addr  = 24'h000999;
    put(24'h000020, 24'h111111);
    tick();
    put(24'h001020, 24'h222222);
    tick();
    put(24'h000020, 24'h333333);
    ld_addr = 24'h000020;
    #1;
    chk("fwd_hit",      {31'd0, ld_hit},      32'd1);
    chk("fwd_data",     {8'd0, ld_data},      32'h222222);
    chk("fwd_conflict", {31'd0, ld_conflict}, 32'd0);
    tick();
    st_valid = 1'b0;
    #1;
    chk("fwd_young_data", {8'd0, ld_data}, 32'h333333);
    ld_addr = 24'h000030;
    #1;
    chk("fwd_miss_hit",  {31'd0, ld_hit}, 32'd0);
    chk("fwd_miss_data", {8'd0, ld_data}, 32'd0);
    ld_valid = 1'b0;
    tick();
    chk("steady_start_count", {28'd0, count}, 32'd2);
    for (int i = 0; i < 10; i++) begin
      put(24'h000700 + 24'(i * 4), 24'h700000 + 24'(i));
      tick();
      chk($sformatf("steady_count_%0d", i), {28'd0, count}, 32'd2);
    end
    drain("steady_drain");
`endif

    // Mid-cycle reset discards buffered stores.
    for (int i = 0; i < 3; i++) begin
      put(24'h000800 + 24'(i), 24'h880000 + 24'(i));
      tick();
    end
    st_valid = 1'b0;
    #3;
    reset = 1'b1;
    sb_q.delete();
    #1;
    chk("midrst_count",    {28'd0, count},    32'd0);
    chk("midrst_empty",    {31'd0, empty},    32'd1);
    chk("midrst_memWrite", {31'd0, memWrite}, 32'd0);
    chk("midrst_st_ready", {31'd0, st_ready}, 32'd1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst_memWrite_%0d", i), {31'd0, memWrite}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
